bist_sig_checker: RTL and testbench
===================================

# bist_sig_checker

Response-side companion to the BIST controller: accepts the stream of function-unit results produced during a self-test session, compresses them bit-serially into a CRC-8 signature and compares it against a golden value at end of session. It sits between the function unit's result output and the status/7-segment display path, and owns the pass/fail verdict that the controller only produces as a raw signature.

## Interface
Parameters:
- `DATA_W`, 5, width of each result word (function unit output width)
- `N_VECTORS`, 256, words per session (1..256)
- `CRC_POLY`, 8'h07, CRC-8 polynomial (x^8 implicit)
- `CRC_INIT`, 8'hAA, signature seed loaded at session start
- `GOLDEN`, 8'h00, expected final signature
- `TIMEOUT_CYC`, 1024, watchdog limit (used only with `BIST_SIG_CHECKER_TIMEOUT_EN`)

Ports:
- `clk_i` in 1: clock, all logic on rising edge
- `rst_ni` in 1: reset, synchronous, active-low
- `start_i` in 1: begin a session (sampled only in IDLE)
- `data_i` in DATA_W: result word
- `valid_i` in 1: `data_i` valid
- `ready_o` out 1: checker can accept a word
- `busy_o` out 1: state != IDLE
- `done_o` out 1: one-cycle end-of-session pulse
- `pass_o` out 1: sticky, signature == GOLDEN
- `fail_o` out 1: sticky, signature != GOLDEN or timeout
- `timeout_o` out 1: sticky, watchdog fired
- `signature_o` out 8: current CRC register
- `count_o` out 9: words accepted this session
- `session_cnt_o` out 4: sessions started since reset, wraps 15->0

## Operation
- States: IDLE, CAPTURE, SHIFT, CHECK.
- IDLE: on `start_i`=1 -> CAPTURE; load CRC <= CRC_INIT, `count_o` <= 0, clear pass/fail/timeout, `session_cnt_o` += 1.
- CAPTURE: `ready_o`=1. On `valid_i`=1 latch `data_i` into shift register, `count_o` += 1 -> SHIFT. `valid_i` outside CAPTURE ignored (no buffering).
- SHIFT: one data bit per cycle, MSB first, DATA_W cycles. Per bit b: fb = crc[7]^b; crc <= {crc[6:0],1'b0} ^ (fb ? CRC_POLY : 8'h00). After last bit: -> CHECK if `count_o` == N_VECTORS, else -> CAPTURE.
- CHECK: one cycle; set `pass_o` = (crc == GOLDEN), `fail_o` = !pass; -> IDLE with `done_o`=1 for the first IDLE cycle.
- `start_i` while busy: ignored, no restart, no session count change.
- `signature_o` always reflects the live CRC register; holds final value in IDLE until next start.
- Reset (`rst_ni`=0 at any edge, incl. mid-session): state IDLE, all outputs 0 (`signature_o`=8'h00, `session_cnt_o`=0); partial session discarded, no `done_o`.

## Timing
- `start_i` at edge t -> `ready_o`=1, `busy_o`=1 from cycle t+1.
- Word accepted at edge k -> `ready_o`=0 for cycles k+1..k+DATA_W; earliest next accept at edge k+DATA_W+1.
- `valid_i` held high: session of N words lasts 1 + N*(DATA_W+1) + 1 cycles from start to first IDLE cycle; `done_o` high in that cycle.
- pass/fail valid in the same cycle as `done_o` and held until next accepted `start_i` or reset.
- `start_i` in the `done_o` cycle is accepted (IDLE).

## Configuration
- `BIST_SIG_CHECKER_TIMEOUT_EN` defined: in CAPTURE, a counter increments each cycle without `valid_i`, clears on accept; reaching TIMEOUT_CYC -> `timeout_o`=1, `fail_o`=1, `pass_o`=0, `done_o` pulse, -> IDLE. Counter cleared on leaving CAPTURE.
- Not defined: no watchdog logic; `timeout_o` tied 0; CAPTURE waits indefinitely.

## Test plan
- N_VECTORS=1, CRC_INIT=8'h00, GOLDEN=8'h07: start, send 5'b00001 -> `signature_o`=8'h07, `pass_o`=1, `fail_o`=0, `done_o` one cycle, 8 cycles start-to-done.
- Same config, send 5'b10000 -> `signature_o`=8'h70, `fail_o`=1, `pass_o`=0.
- N_VECTORS=256, `valid_i` held high, toggling `start_i` during session -> ignored; `count_o`=256 at done; `session_cnt_o`=1; `ready_o` low exactly 5 cycles after each accept.
- `rst_ni`=0 after 100 accepted words -> next cycle all outputs 0, state IDLE, no `done_o`; new start runs a full clean session.
- 17 sessions back-to-back -> `session_cnt_o` reads 1..15, 0, 1.
- With `BIST_SIG_CHECKER_TIMEOUT_EN`, TIMEOUT_CYC=16: start, no `valid_i` -> at 16 idle cycles `timeout_o`=1, `fail_o`=1, `done_o` pulse; without macro, same stimulus keeps `busy_o`=1, `timeout_o`=0.

Source files
------------

// File: rtl/bist_sig_checker.sv
// bist_sig_checker: bit-serial CRC-8 response compactor with golden-signature verdict.
// Optional capture watchdog enabled by defining BIST_SIG_CHECKER_TIMEOUT_EN.
module bist_sig_checker #(
  parameter int unsigned DATA_W      = 5,
  parameter int unsigned N_VECTORS   = 256,
  parameter logic [7:0]  CRC_POLY    = 8'h07,
  parameter logic [7:0]  CRC_INIT    = 8'hAA,
  parameter logic [7:0]  GOLDEN      = 8'h00,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic              fail_o,
  output logic              timeout_o,
  output logic [7:0]        signature_o,
  output logic [8:0]        count_o,
  output logic [3:0]        session_cnt_o
);

  localparam int unsigned BCW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [8:0]  NV  = 9'(N_VECTORS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_SHIFT,
    S_CHECK
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        crc_q, crc_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [BCW-1:0]    bitcnt_q, bitcnt_d;
  logic [8:0]        count_q, count_d;
  logic [3:0]        sess_q, sess_d;
  logic              pass_q, pass_d;
  logic              fail_q, fail_d;
  logic              done_q, done_d;
  logic              timeout_flag;
  logic              wdog_fire;
  logic              fb;

`ifdef BIST_SIG_CHECKER_TIMEOUT_EN
  localparam int unsigned WDW = $clog2(TIMEOUT_CYC + 1);

  logic [WDW-1:0] wdog_q, wdog_d;
  logic           timeout_q, timeout_d;

  assign wdog_fire = (state_q == S_CAPTURE) && !valid_i &&
                     (wdog_q == WDW'(TIMEOUT_CYC - 1));

  always_comb begin
    wdog_d    = wdog_q;
    timeout_d = timeout_q;
    if (state_q == S_IDLE && start_i) begin
      timeout_d = 1'b0;
    end
    if (state_q == S_CAPTURE) begin
      if (valid_i || wdog_fire) wdog_d = '0;
      else                      wdog_d = wdog_q + WDW'(1);
      if (wdog_fire) timeout_d = 1'b1;
    end else begin
      wdog_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_flag = timeout_q;
`else
  // No watchdog: CAPTURE waits indefinitely; TIMEOUT_CYC has no effect here.
  assign wdog_fire    = 1'b0 && (TIMEOUT_CYC != 0);
  assign timeout_flag = 1'b0;
`endif

  // State register and datapath registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      crc_q    <= '0;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      count_q  <= '0;
      sess_q   <= '0;
      pass_q   <= 1'b0;
      fail_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      crc_q    <= crc_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      count_q  <= count_d;
      sess_q   <= sess_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (start_i) state_d = S_CAPTURE;
      S_CAPTURE: begin
        if (valid_i)        state_d = S_SHIFT;
        else if (wdog_fire) state_d = S_IDLE;
      end
      S_SHIFT:   if (bitcnt_q == '0) state_d = (count_q == NV) ? S_CHECK : S_CAPTURE;
      S_CHECK:   state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    crc_d    = crc_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    count_d  = count_q;
    sess_d   = sess_q;
    pass_d   = pass_q;
    fail_d   = fail_q;
    done_d   = 1'b0;
    fb       = crc_q[7] ^ shreg_q[DATA_W-1];
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          crc_d   = CRC_INIT;
          count_d = '0;
          pass_d  = 1'b0;
          fail_d  = 1'b0;
          sess_d  = sess_q + 4'd1;
        end
      end
      S_CAPTURE: begin
        if (valid_i) begin
          shreg_d  = data_i;
          bitcnt_d = BCW'(DATA_W - 1);
          count_d  = count_q + 9'd1;
        end else if (wdog_fire) begin
          pass_d = 1'b0;
          fail_d = 1'b1;
          done_d = 1'b1;
        end
      end
      S_SHIFT: begin
        crc_d    = {crc_q[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
        shreg_d  = shreg_q << 1;
        bitcnt_d = bitcnt_q - BCW'(1);
      end
      S_CHECK: begin
        pass_d = (crc_q == GOLDEN);
        fail_d = (crc_q != GOLDEN);
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    ready_o       = (state_q == S_CAPTURE);
    busy_o        = (state_q != S_IDLE);
    done_o        = done_q;
    pass_o        = pass_q;
    fail_o        = fail_q;
    timeout_o     = timeout_flag;
    signature_o   = crc_q;
    count_o       = count_q;
    session_cnt_o = sess_q;
  end

endmodule

// File: tb/tb_bist_sig_checker.sv
// Directed self-checking bench for bist_sig_checker: a 1-word session instance (A)
// and a 256-word default instance (B) sharing clock and reset.
module tb_bist_sig_checker;

  logic       clk;
  logic       rst_n;

  logic       start_a, valid_a;
  logic [4:0] data_a;
  logic       ready_a, busy_a, done_a, pass_a, fail_a, tmo_a;
  logic [7:0] sig_a;
  logic [8:0] cnt_a;
  logic [3:0] sess_a;

  logic       start_b, valid_b;
  logic [4:0] data_b;
  logic       ready_b, busy_b, done_b, pass_b, fail_b, tmo_b;
  logic [7:0] sig_b;
  logic [8:0] cnt_b;
  logic [3:0] sess_b;

  int vecs = 0;
  int errs = 0;

  bist_sig_checker #(
    .DATA_W(5), .N_VECTORS(1), .CRC_POLY(8'h07), .CRC_INIT(8'h00),
    .GOLDEN(8'h07), .TIMEOUT_CYC(16)
  ) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_a), .data_i(data_a),
    .valid_i(valid_a), .ready_o(ready_a), .busy_o(busy_a), .done_o(done_a),
    .pass_o(pass_a), .fail_o(fail_a), .timeout_o(tmo_a), .signature_o(sig_a),
    .count_o(cnt_a), .session_cnt_o(sess_a)
  );

  bist_sig_checker #(
    .DATA_W(5), .N_VECTORS(256), .CRC_POLY(8'h07), .CRC_INIT(8'hAA),
    .GOLDEN(8'h00), .TIMEOUT_CYC(1024)
  ) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_b), .data_i(data_b),
    .valid_i(valid_b), .ready_o(ready_b), .busy_o(busy_b), .done_o(done_b),
    .pass_o(pass_b), .fail_o(fail_b), .timeout_o(tmo_b), .signature_o(sig_b),
    .count_o(cnt_b), .session_cnt_o(sess_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] crc_word(input logic [7:0] c_in, input logic [4:0] d);
    logic [7:0] c;
    logic       f;
    c = c_in;
    for (int i = 4; i >= 0; i--) begin
      f = c[7] ^ d[i];
      c = {c[6:0], 1'b0};
      if (f) c = c ^ 8'h07;
    end
    return c;
  endfunction

  task automatic wait_done_a(input int limit, output int n);
    n = 0;
    while (!done_a && n < limit) begin
      step();
      n++;
    end
  endtask

  task automatic check_b_zero(input string tag);
    check({tag, "_b_ready"}, 32'(ready_b), 0);
    check({tag, "_b_busy"},  32'(busy_b),  0);
    check({tag, "_b_done"},  32'(done_b),  0);
    check({tag, "_b_pass"},  32'(pass_b),  0);
    check({tag, "_b_fail"},  32'(fail_b),  0);
    check({tag, "_b_tmo"},   32'(tmo_b),   0);
    check({tag, "_b_sig"},   32'(sig_b),   0);
    check({tag, "_b_cnt"},   32'(cnt_b),   0);
    check({tag, "_b_sess"},  32'(sess_b),  0);
  endtask

  // Full 256-word session on B with valid held high and start toggling mid-session.
  task automatic run_b_session(input string tag);
    int         edges;
    int         lowrun;
    int         runs;
    int         badruns;
    logic [7:0] model;
    model = 8'hAA;
    for (int w = 0; w < 256; w++) model = crc_word(model, 5'h15);
    data_b  = 5'h15;
    valid_b = 1'b1;
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    check({tag, "_busy_after_start"}, 32'(busy_b), 1);
    check({tag, "_sess_after_start"}, 32'(sess_b), 1);
    edges = 0; lowrun = 0; runs = 0; badruns = 0;
    while (!done_b && edges < 2000) begin
      start_b = ~start_b;
      step();
      edges++;
      if (!ready_b) lowrun++;
      else begin
        if (lowrun != 0) begin
          runs++;
          if (lowrun != 5) badruns++;
        end
        lowrun = 0;
      end
    end
    start_b = 1'b0;
    check({tag, "_done"},     32'(done_b), 1);
    check({tag, "_edges"},    32'(edges), 1537);
    check({tag, "_ready_runs"}, 32'(runs), 255);
    check({tag, "_bad_low_runs"}, 32'(badruns), 0);
    check({tag, "_count"},    32'(cnt_b), 256);
    check({tag, "_sess"},     32'(sess_b), 1);
    check({tag, "_sig"},      32'(sig_b), 32'(model));
    check({tag, "_pass"},     32'(pass_b), 32'(model == 8'h00));
    check({tag, "_fail"},     32'(fail_b), 32'(model != 8'h00));
    check({tag, "_busy_end"}, 32'(busy_b), 0);
    step();
    check({tag, "_done_1cyc"}, 32'(done_b), 0);
    check({tag, "_sig_hold"},  32'(sig_b), 32'(model));
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    start_a = 1'b0; valid_a = 1'b0; data_a = '0;
    start_b = 1'b0; valid_b = 1'b0; data_b = '0;
    step();
    step();
    check("rst_a_busy", 32'(busy_a), 0);
    check("rst_a_sig",  32'(sig_a),  0);
    check("rst_a_sess", 32'(sess_a), 0);
    check_b_zero("rst");
    rst_n = 1'b1;
    step();

    // A: 00001 with INIT 00 -> 07, matches golden
    data_a = 5'b00001; valid_a = 1'b1; start_a = 1'b1;
    step();
    start_a = 1'b0;
    check("a1_ready",  32'(ready_a), 1);
    check("a1_busy",   32'(busy_a),  1);
    check("a1_sess",   32'(sess_a),  1);
    check("a1_seed",   32'(sig_a),   0);
    wait_done_a(20, n);
    check("a1_done",   32'(done_a), 1);
    check("a1_edges",  32'(n), 7);
    check("a1_sig",    32'(sig_a), 32'h07);
    check("a1_pass",   32'(pass_a), 1);
    check("a1_fail",   32'(fail_a), 0);
    check("a1_count",  32'(cnt_a), 1);
    step();
    check("a1_done_1cyc", 32'(done_a), 0);
    check("a1_sig_hold",  32'(sig_a), 32'h07);
    check("a1_pass_hold", 32'(pass_a), 1);
    check("a1_idle_valid_ignored", 32'(cnt_a), 1);

    // A: 10000 -> 70, fails golden
    data_a = 5'b10000; start_a = 1'b1;
    step();
    start_a = 1'b0;
    check("a2_pass_clr", 32'(pass_a), 0);
    check("a2_sig_seed", 32'(sig_a), 0);
    wait_done_a(20, n);
    check("a2_done", 32'(done_a), 1);
    check("a2_sig",  32'(sig_a), 32'h70);
    check("a2_fail", 32'(fail_a), 1);
    check("a2_pass", 32'(pass_a), 0);

    // start in the done cycle is accepted
    data_a = 5'b00001; start_a = 1'b1;
    step();
    start_a = 1'b0;
    check("a3_busy", 32'(busy_a), 1);
    check("a3_sess", 32'(sess_a), 3);
    check("a3_fail_clr", 32'(fail_a), 0);
    wait_done_a(20, n);
    check("a3_edges", 32'(n), 7);
    check("a3_pass",  32'(pass_a), 1);

    // B: full session, then reset after 100 words, then a clean full session
    run_b_session("b1");
    data_b = 5'h15; valid_b = 1'b1; start_b = 1'b1;
    step();
    start_b = 1'b0;
    n = 0;
    while (cnt_b != 9'd100 && n < 1000) begin
      step();
      n++;
    end
    check("b2_reached_100", 32'(cnt_b), 100);
    rst_n = 1'b0;
    step();
    check_b_zero("midrst");
    check("midrst_a_sess", 32'(sess_a), 0);
    rst_n = 1'b1;
    step();
    check("midrst_no_done", 32'(done_b), 0);
    run_b_session("b3");

    // A: 17 back-to-back sessions, counter wraps 15 -> 0
    data_a = 5'b00001; valid_a = 1'b1; start_a = 1'b1;
    for (int i = 0; i < 17; i++) begin
      step();
      start_a = 1'b0;
      check($sformatf("sess_%0d", i), 32'(sess_a), 32'((i + 1) % 16));
      wait_done_a(20, n);
      check($sformatf("sess_done_%0d", i), 32'(done_a), 1);
      if (i < 16) start_a = 1'b1;
    end
    start_a = 1'b0;
    step();

    // A: no valid after start
    valid_a = 1'b0; start_a = 1'b1;
    step();
    start_a = 1'b0;
`ifdef BIST_SIG_CHECKER_TIMEOUT_EN
    wait_done_a(40, n);
    check("tmo_done",  32'(done_a), 1);
    check("tmo_edges", 32'(n), 16);
    check("tmo_flag",  32'(tmo_a), 1);
    check("tmo_fail",  32'(fail_a), 1);
    check("tmo_pass",  32'(pass_a), 0);
    check("tmo_busy",  32'(busy_a), 0);
`else
    wait_done_a(40, n);
    check("notmo_no_done", 32'(done_a), 0);
    check("notmo_busy",    32'(busy_a), 1);
    check("notmo_ready",   32'(ready_a), 1);
    check("notmo_flag",    32'(tmo_a), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
